// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one-cycle-latency memory reads on credit and
// buffers {pc, instr} pairs in a DEPTH-entry FIFO for decode.
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PcIn,
  input  logic        PcValid,
  output logic        PcReady,
  input  logic        Flush,
  output logic        ImemRdEn,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPc,
  output logic        InstrValid,
  input  logic        InstrReady
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_pc_q    [DEPTH];
  logic [31:0]   mem_instr_q [DEPTH];

  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   hold_pc_q, hold_pc_d;
  logic [31:0]   hold_instr_q, hold_instr_d;

  logic [AW+1:0] used;
  logic          accept;
  logic          push;
  logic          pop;

  // In-flight read reserves a slot so its response always has room.
  assign used     = {1'b0, count_q} + (AW+2)'(inflight_q);
  assign PcReady  = !rst && !Flush && (used < (AW+2)'(DEPTH));
  assign accept   = PcValid && PcReady;
  assign push     = inflight_q && !Flush;
  assign pop      = InstrValid && InstrReady && !Flush;

  assign ImemRdEn   = accept;
  assign ImemAddr   = accept ? PcIn : addr_q;
  assign InstrValid = (count_q != '0);
  assign InstrOut   = InstrValid ? mem_instr_q[rd_ptr_q] : hold_instr_q;
  assign InstrPc    = InstrValid ? mem_pc_q[rd_ptr_q] : hold_pc_q;

  always_comb begin
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    inflight_d   = accept;
    pc_d         = pc_q;
    addr_d       = addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;

    if (accept) begin
      pc_d   = PcIn;
      addr_d = PcIn;
    end

    // Remember whatever was last presented so an empty queue shows it steadily.
    if (InstrValid) begin
      hold_pc_d    = mem_pc_q[rd_ptr_q];
      hold_instr_d = mem_instr_q[rd_ptr_q];
    end

    if (Flush) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      inflight_q   <= 1'b0;
      pc_q         <= '0;
      addr_q       <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      inflight_q   <= inflight_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= ImemRdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model with a scoreboard.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PcIn = '0;
  logic        PcValid = 1'b0;
  logic        PcReady;
  logic        Flush = 1'b0;
  logic        ImemRdEn;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata = '0;
  logic [31:0] InstrOut;
  logic [31:0] InstrPc;
  logic        InstrValid;
  logic        InstrReady = 1'b0;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PcIn(PcIn), .PcValid(PcValid), .PcReady(PcReady),
    .Flush(Flush), .ImemRdEn(ImemRdEn), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata),
    .InstrOut(InstrOut), .InstrPc(InstrPc), .InstrValid(InstrValid),
    .InstrReady(InstrReady)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Reference model: sb is the FIFO contents in accept order.
  logic [63:0] sb[$];
  bit          infl = 1'b0;
  logic [31:0] infl_pc = '0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_instr = '0;
  int          pops = 0;
  bit          rsp_pend = 1'b0;
  logic [31:0] rsp_a = '0;

  always @(negedge clk) begin
    bit exp_ready, acc, exp_valid;
    rsp_pend = (ImemRdEn === 1'b1);
    rsp_a    = ImemAddr;
    if (rst) begin
      chk("ready_in_reset", 32'(PcReady), 32'd0);
      chk("rden_in_reset", 32'(ImemRdEn), 32'd0);
      sb.delete();
      infl = 1'b0; infl_pc = '0; last_addr = '0; last_pc = '0; last_instr = '0;
    end else begin
      exp_ready = !Flush && ((sb.size() + int'(infl)) < DEPTH);
      acc       = PcValid && exp_ready;
      exp_valid = (sb.size() > 0);
      chk("pc_ready", 32'(PcReady), 32'(exp_ready));
      chk("imem_rden", 32'(ImemRdEn), 32'(acc));
      chk("imem_addr", ImemAddr, acc ? PcIn : last_addr);
      chk("instr_valid", 32'(InstrValid), 32'(exp_valid));
      if (exp_valid) begin
        chk("head_pc", InstrPc, sb[0][63:32]);
        chk("head_instr", InstrOut, sb[0][31:0]);
        last_pc    = sb[0][63:32];
        last_instr = sb[0][31:0];
      end else begin
        chk("hold_pc", InstrPc, last_pc);
        chk("hold_instr", InstrOut, last_instr);
      end
      if (Flush) begin
        sb.delete();
        infl = 1'b0;
      end else begin
        if (exp_valid && InstrReady) begin
          void'(sb.pop_front());
          pops++;
        end
        if (infl) sb.push_back({infl_pc, memf(infl_pc)});
        infl    = acc;
        infl_pc = PcIn;
      end
      if (acc) last_addr = PcIn;
    end
  end

  // Memory answers one cycle after a read strobe; otherwise the bus carries junk.
  always @(posedge clk) begin
    #1;
    ImemRdata = rsp_pend ? memf(rsp_a) : $urandom;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    repeat (2) cyc();
    rst = 1'b0;

    // single fetch
    InstrReady = 1'b1; PcIn = 32'h10; PcValid = 1'b1;
    @(negedge clk);
    chk("single_rden", 32'(ImemRdEn), 32'd1);
    chk("single_addr", ImemAddr, 32'h10);
    cyc(); PcValid = 1'b0;
    @(negedge clk);
    chk("single_n1_valid", 32'(InstrValid), 32'd0);
    cyc();
    @(negedge clk);
    chk("single_n2_valid", 32'(InstrValid), 32'd1);
    chk("single_n2_pc", InstrPc, 32'h10);
    chk("single_n2_instr", InstrOut, memf(32'h10));
    repeat (4) cyc();

    // fill, then full plus pop
    InstrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      PcIn = 32'(i); PcValid = 1'b1;
      @(negedge clk);
      chk("fill_ready", 32'(PcReady), (i < 4) ? 32'd1 : 32'd0);
      cyc();
    end
    PcValid = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("full_valid", 32'(InstrValid), 32'd1);
    chk("full_head_pc", InstrPc, 32'd0);
    chk("full_ready", 32'(PcReady), 32'd0);
    cyc(); InstrReady = 1'b1;
    @(negedge clk);
    chk("pop_cycle_ready", 32'(PcReady), 32'd0);
    cyc(); InstrReady = 1'b0;
    @(negedge clk);
    chk("after_pop_ready", 32'(PcReady), 32'd1);
    cyc(); InstrReady = 1'b1;
    repeat (5) cyc();

    // three fill/drain rounds to exercise pointer wrap
    for (int r = 0; r < 3; r++) begin
      InstrReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
        PcIn = 32'(100 * (r + 1) + i); PcValid = 1'b1;
        cyc();
      end
      PcValid = 1'b0;
      repeat (2) cyc();
      @(negedge clk);
      chk("wrap_full_ready", 32'(PcReady), 32'd0);
      chk("wrap_head_pc", InstrPc, 32'(100 * (r + 1)));
      cyc(); InstrReady = 1'b1;
      repeat (5) cyc();
      @(negedge clk);
      chk("wrap_empty", 32'(InstrValid), 32'd0);
      cyc();
    end

    // streaming
    InstrReady = 1'b1;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      PcIn = 32'(i); PcValid = 1'b1;
      cyc();
    end
    PcValid = 1'b0;
    repeat (2) cyc();
    chk("stream_pops", 32'(pops - p0), 32'd20);
    repeat (3) cyc();

    // flush with PCs 5,6 queued and 7 in flight
    InstrReady = 1'b0;
    for (int i = 5; i < 8; i++) begin
      PcIn = 32'(i); PcValid = 1'b1;
      cyc();
    end
    PcValid = 1'b0; Flush = 1'b1;
    @(negedge clk);
    chk("preflush_head", InstrPc, 32'd5);
    cyc();
    Flush = 1'b0; PcIn = 32'h40; PcValid = 1'b1;
    @(negedge clk);
    chk("flush_empty", 32'(InstrValid), 32'd0);
    chk("flush_ready", 32'(PcReady), 32'd1);
    cyc();
    PcValid = 1'b0; InstrReady = 1'b1;
    cyc();
    @(negedge clk);
    chk("flush_first_valid", 32'(InstrValid), 32'd1);
    chk("flush_first_pc", InstrPc, 32'h40);
    repeat (3) cyc();

    // reset mid-operation with three entries queued
    InstrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PcIn = 32'h200 + 32'(i); PcValid = 1'b1;
      cyc();
    end
    PcValid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_instr", InstrOut, 32'd0);
    chk("rst_pc", InstrPc, 32'd0);
    chk("rst_ready", 32'(PcReady), 32'd1);
    cyc();

    // random traffic
    repeat (600) begin
      PcValid    = ($urandom_range(0, 3) != 0);
      PcIn       = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 63));
      InstrReady = ($urandom_range(0, 2) != 0);
      Flush      = ($urandom_range(0, 24) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      cyc();
    end
    PcValid = 1'b0; Flush = 1'b0; rst = 1'b0; InstrReady = 1'b1;
    repeat (6) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, queue entries (power of two, >= 2).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port PcIn, input, 32, word address from the program counter.
REQ-006 The block SHALL have port PcValid, input, 1, PcIn is a fetch request.
REQ-007 The block SHALL have port PcReady, output, 1, request accepted this cycle when PcValid is also 1.
REQ-008 The block SHALL have port Flush, input, 1, redirect: discard all queued and in-flight fetches.
REQ-009 The block SHALL have port ImemRdEn, output, 1, instruction memory read strobe.
REQ-010 The block SHALL have port ImemAddr, output, 32, instruction memory word address.
REQ-011 The block SHALL have port ImemRdata, input, 32, read data, valid exactly 1 cycle after ImemRdEn.
REQ-012 The block SHALL have port InstrOut, output, 32, instruction at queue head.
REQ-013 The block SHALL have port InstrPc, output, 32, address of InstrOut.
REQ-014 The block SHALL have port InstrValid, output, 1, queue head valid.
REQ-015 The block SHALL have port InstrReady, input, 1, decode consumes head when InstrValid is also 1.

Function
REQ-016 The block SHALL hold a FIFO of DEPTH {pc, instr} entries: wrap-around pointers modulo DEPTH, occupancy count of width log2(DEPTH)+1.
REQ-017 The block SHALL track one in-flight bit, set on accept and cleared the following cycle.
REQ-018 PcReady SHALL be 1 iff (count + inflight) < DEPTH and Flush = 0; it is evaluated from registered state only, with no same-cycle pop bypass.
REQ-019 On accept (PcValid & PcReady), ImemRdEn SHALL be 1 combinationally in the same cycle with ImemAddr = PcIn; otherwise ImemRdEn = 0 and ImemAddr holds its last driven value.
REQ-020 In the cycle after an accept, the block SHALL write {registered PC, ImemRdata} at the tail on the clock edge.
REQ-021 Latency SHALL be as follows: with the queue empty, a request accepted in cycle N gives InstrValid = 1 in cycle N+2.
REQ-022 Throughput SHALL be one accept per cycle sustained while credit is available.
REQ-023 InstrValid SHALL be 1 iff count > 0; InstrOut and InstrPc are driven from the head entry.
REQ-024 Pop SHALL occur when InstrValid & InstrReady; simultaneous push and pop leaves count unchanged and both pointers advance.
REQ-025 When full (count = DEPTH), PcReady SHALL be 0; the head SHALL be held stable until popped.
REQ-026 When empty, InstrValid SHALL be 0, InstrOut and InstrPc hold their last values, and InstrReady is ignored.
REQ-027 Flush SHALL have priority over push, pop and accept: on the edge, count, pointers and inflight clear to 0, and no memory read is issued that cycle.
REQ-028 A response returning in the cycle Flush is asserted SHALL be dropped.
REQ-029 A request accepted in the cycle after Flush SHALL be handled normally.
REQ-030 Entry order SHALL equal accept order; no reordering or duplication is permitted.

Reset
REQ-031 While rst = 1 on a clock edge, the block SHALL clear count, read and write pointers, inflight and the PC register to 0.
REQ-032 After reset, outputs SHALL be: InstrValid = 0, InstrOut = 0, InstrPc = 0, ImemRdEn = 0, ImemAddr = 0.
REQ-033 PcReady SHALL be 0 during the reset cycle.
REQ-034 Reset SHALL take priority over Flush and all handshakes; a fetch in flight at reset is discarded.
REQ-035 Storage array contents SHALL not need clearing.

Verification
REQ-036 The bench SHALL cover single fetch: PcIn = 0x10, PcValid for one cycle at N, InstrReady = 1 -> ImemRdEn = 1 with ImemAddr = 0x10 at N; InstrValid = 1, InstrPc = 0x10, InstrOut = mem[0x10] at N+2.
REQ-037 The bench SHALL cover fill: PcIn = 0,1,2,3,4 on consecutive cycles, InstrReady = 0 -> accepts 0..3, PcReady = 0 from the cycle after the 4th accept, count = 4, head InstrPc = 0.
REQ-038 The bench SHALL cover streaming: PcValid and InstrReady held at 1 for 20 cycles on PCs 0..19 -> 20 instructions in order, one per cycle after 2-cycle fill, no gaps.
REQ-039 The bench SHALL cover flush mid-flight: queue holding PCs 5,6 with PC 7 in flight, Flush pulse -> next cycle InstrValid = 0, count = 0; PC 7 data is never presented; new PC 0x40 then emerges first.
REQ-040 The bench SHALL cover reset mid-operation: queue holding 3 entries, rst high for 1 cycle -> InstrValid = 0, InstrOut = 0, InstrPc = 0, PcReady = 1 the following cycle.
REQ-041 The bench SHALL cover full plus pop: count = 4, InstrReady = 1 for one cycle -> PcReady stays 0 that cycle and becomes 1 the next cycle; pointer wrap is verified over 3 full fill and drain rounds.
